// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan path: glyph table,
// inactive anode/cathode patterns, digit-index type and the captured
// frame record.
package seg_scan_driver_pkg;

  // Index of the digit being scanned: 0=A (leftmost) .. 3=D (rightmost).
  typedef logic [1:0] digit_idx_t;

  // Cathode and anode patterns with every segment/digit switched off.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low glyphs, bit order g,f,e,d,c,b,a, for hex codes 0..F.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // One full frame of display content, latched once per scan.
  // digit[0] holds A, digit[3] holds D.  blank/dp_en use the port
  // mapping: bit3=A .. bit0=D.
  typedef struct packed {
    logic [3:0][3:0] digit;
    logic [3:0]      blank;
    logic [3:0]      dp_en;
  } frame_t;

  // Content loaded by reset: all digits blanked so the display stays
  // dark until the first real capture.
  localparam frame_t FRAME_RESET = '{digit: '0, blank: 4'b1111, dp_en: 4'b0000};

  // Bit position in the an/blank/dp_en vectors for a given digit index.
  function automatic logic [1:0] digit_bit(input digit_idx_t idx);
    return 2'd3 - idx;
  endfunction

  // Active-low one-cold anode pattern selecting a single digit.
  function automatic logic [3:0] an_select(input digit_idx_t idx);
    return ~(4'b1000 >> idx);
  endfunction

endpackage

// File: rtl/seg_scan_driver_hex_to_seg.sv
// Combinational hex-to-seven-segment decoder (active-low cathodes).
// Kept standalone so other display stages can reuse the same glyphs.
module hex_to_seg
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Straight table lookup into the shared glyph constants.
  always_comb begin
    seg_o = SEG_GLYPH[hex_i];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a four-digit common-anode display.
// Each digit owns CLK_DIV clocks; the first DEAD_CYCLES of every slot
// are blanked to stop the previous digit ghosting onto the next one.
// Display content is latched once per frame so a digit never changes
// part way through a scan.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int CLK_DIV     = 100000,
  parameter int DEAD_CYCLES = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic [3:0] blank,
  input  logic [3:0] dp_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);

  // The slot must hold the blanking window plus at least two lit cycles.
  if (!(CLK_DIV >= DEAD_CYCLES + 2 && DEAD_CYCLES >= 0)) begin : g_bad_params
    $error("seg_scan_driver: requires CLK_DIV >= DEAD_CYCLES+2 and DEAD_CYCLES >= 0");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  frame_t           frame_q, frame_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_done_q;

  logic             slot_end;
  logic             capture;
  logic [1:0]       pos_d;
  logic [3:0]       digit_d;
  logic [6:0]       glyph_d;
  logic             dark_d;

  // Decode the digit that will be on display in the next cycle.
  hex_to_seg u_hex_to_seg (
    .hex_i (digit_d),
    .seg_o (glyph_d)
  );

  // Next-state for the scan position, the frame latch and the outputs.
  // Outputs are derived from the *next* position and frame so that the
  // registered value lines up with the cnt/idx it is registered beside.
  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    capture  = slot_end && (idx_q == 2'd3);

    cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d = slot_end ? idx_q + 2'd1 : idx_q;

    frame_d = frame_q;
    if (capture) begin
      frame_d.digit = {D, C, B, A};
      frame_d.blank = blank;
      frame_d.dp_en = dp_en;
    end

    pos_d   = digit_bit(idx_d);
    digit_d = frame_d.digit[idx_d];
    dark_d  = (cnt_d < CNT_DEAD) || frame_d.blank[pos_d];

    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!dark_d) begin
      an_d  = an_select(idx_d);
      seg_d = glyph_d;
      dp_d  = ~frame_d.dp_en[pos_d];
    end
  end

  // State and output registers; reset wins over capture and frame_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_q      <= FRAME_RESET;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= capture;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with CLK_DIV=8, DEAD_CYCLES=2.
module tb_seg_scan_driver;

  localparam int DIV  = 8;
  localparam int DEAD = 2;
  localparam int FRM  = 4 * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] A, B, C, D, blank, dp_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, frame_done;

  int vectors = 0;
  int errors  = 0;

  seg_scan_driver #(.CLK_DIV(DIV), .DEAD_CYCLES(DEAD)) dut (
    .clk(clk), .reset(reset),
    .A(A), .B(B), .C(C), .D(D),
    .blank(blank), .dp_en(dp_en),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Independent glyph table (g..a, active low).
  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Reference model: t = cycles since the last reset edge; the shown
  // frame is whatever the inputs were at the last frame boundary.
  int         mt = 0;
  bit         started = 0;
  logic [3:0] mdig [4];
  logic [3:0] mblank, mdp;

  always @(posedge clk) begin
    if (reset) begin
      mt = 0;
      started = 1;
      for (int i = 0; i < 4; i++) mdig[i] = 4'h0;
      mblank = 4'b1111;
      mdp    = 4'b0000;
    end else if (started) begin
      if (mt % FRM == FRM - 1) begin
        mdig[0] = A; mdig[1] = B; mdig[2] = C; mdig[3] = D;
        mblank = blank;
        mdp    = dp_en;
      end
      mt = mt + 1;
    end
  end

  function automatic logic [11:0] expect_now();
    int cnt, idx, pos;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fd;
    cnt = mt % DIV;
    idx = (mt / DIV) % 4;
    pos = 3 - idx;
    e_fd = (mt > 0) && (mt % FRM == 0);
    if (cnt < DEAD || mblank[pos]) begin
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
    end else begin
      e_an = 4'b1111;
      e_an[pos] = 1'b0;
      e_seg = glyph(mdig[idx]);
      e_dp = ~mdp[pos];
    end
    return {e_an, e_seg, e_dp ^ 1'b0, e_fd} >> 0 == 0 ? 12'h0 : {e_an, e_seg, e_dp} ;
  endfunction

  // Per-cycle compare against the model, plus the one-anode rule.
  always @(negedge clk) begin
    if (started && !reset) begin
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic e_dp, e_fd;
      int cnt, idx, pos;
      cnt = mt % DIV;
      idx = (mt / DIV) % 4;
      pos = 3 - idx;
      e_fd = (mt > 0) && (mt % FRM == 0);
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
      if (!(cnt < DEAD || mblank[pos])) begin
        e_an[pos] = 1'b0;
        e_seg = glyph(mdig[idx]);
        e_dp = ~mdp[pos];
      end
      vectors++;
      if (an !== e_an || seg !== e_seg || dp !== e_dp || frame_done !== e_fd) begin
        errors++;
        $display("FAIL cycle t=%0d: an=%b seg=%b dp=%b fd=%b, required an=%b seg=%b dp=%b fd=%b",
                 mt, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      vectors++;
      if ($countones(~an) > 1 || $isunknown(an)) begin
        errors++;
        $display("FAIL one_anode t=%0d: an=%b, required at most one low bit", mt, an);
      end
    end
  end

  task automatic check_lit(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp, input logic e_fd);
    vectors++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp || frame_done !== e_fd) begin
      errors++;
      $display("FAIL %s t=%0d: an=%b seg=%b dp=%b fd=%b, required an=%b seg=%b dp=%b fd=%b",
               name, mt, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
    end
  endtask

  task automatic wait_t(input int target);
    int n = 0;
    while (mt != target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (mt != target) begin
      vectors++;
      errors++;
      $display("FAIL wait_t: reached t=%0d, required t=%0d", mt, target);
    end
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    while (mt % FRM != ph && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (mt % FRM != ph) begin
      vectors++;
      errors++;
      $display("FAIL wait_phase: phase %0d, required %0d", mt % FRM, ph);
    end
  endtask

  initial begin
    int n_fd;
    reset = 1'b1;
    A = 4'd1; B = 4'd2; C = 4'd3; D = 4'd4;
    blank = 4'b0000; dp_en = 4'b0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Dark first frame, then A/B of the second frame.
    check_lit("reset_cycle0", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    wait_t(5);   check_lit("dark_frame0", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    wait_t(31);  check_lit("dark_end", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    wait_t(32);  check_lit("frame_done", 4'b1111, 7'b1111111, 1'b1, 1'b1);
    wait_t(33);  check_lit("A_dead", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    wait_t(34);  check_lit("A_digit1", 4'b0111, 7'b1111001, 1'b1, 1'b0);
    wait_t(42);  check_lit("B_digit2", 4'b1011, 7'b0100100, 1'b1, 1'b0);

    // Mid-frame change of A only shows up in the next frame.
    wait_t(43);  A = 4'd8;
    wait_t(50);  check_lit("C_digit3", 4'b1101, 7'b0110000, 1'b1, 1'b0);
    wait_t(66);  check_lit("A_digit8", 4'b0111, 7'b0000000, 1'b1, 1'b0);

    // Blank B only.
    wait_t(70);  blank = 4'b0100;
    wait_t(98);  check_lit("A_unblanked", 4'b0111, 7'b0000000, 1'b1, 1'b0);
    wait_t(106); check_lit("B_blanked", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    wait_t(108); blank = 4'b0000; dp_en = 4'b0001;
    wait_t(114); check_lit("C_after_blank", 4'b1101, 7'b0110000, 1'b1, 1'b0);

    // Decimal point on D only.
    wait_t(146); check_lit("C_no_dp", 4'b1101, 7'b0110000, 1'b1, 1'b0);
    wait_t(153); check_lit("D_dead_dp", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    wait_t(154); check_lit("D_dp", 4'b1110, 7'b0011001, 1'b0, 1'b0);

    // Randomised content changing at random moments.
    repeat (8 * FRM) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        A = 4'($urandom_range(15)); B = 4'($urandom_range(15));
        C = 4'($urandom_range(15)); D = 4'($urandom_range(15));
        blank = 4'($urandom_range(15)) & 4'($urandom_range(15));
        dp_en = 4'($urandom_range(15));
      end
    end

    // One-cycle reset at idx=2, cnt=5.
    wait_phase(2 * DIV + 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_lit("mid_reset", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    A = 4'd5; B = 4'd6; C = 4'd7; D = 4'd9; blank = 4'b0000; dp_en = 4'b1000;
    wait_t(20); check_lit("dark_after_reset", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    wait_t(34); check_lit("A_after_reset", 4'b0111, 7'b0010010, 1'b0, 1'b0);

    // Reset coincident with the capture edge suppresses frame_done.
    wait_phase(FRM - 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_lit("reset_on_capture", 4'b1111, 7'b1111111, 1'b1, 1'b0);

    // Free run: exactly ten frame_done pulses in ten frames.
    wait_t(1);
    n_fd = 0;
    repeat (10 * FRM) begin
      if (frame_done === 1'b1) n_fd++;
      @(negedge clk);
    end
    vectors++;
    if (n_fd != 10) begin
      errors++;
      $display("FAIL fd_count: got %0d pulses, required 10", n_fd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter CLK_DIV, default 100000, meaning clk cycles per digit slot (1 kHz per digit at 100 MHz).
REQ-002 Parameter DEAD_CYCLES, default 100, meaning anti-ghost blanking cycles at the start of each slot.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 A, B, C, D  input  4 each  hex digit codes from the countdown/ready-set-go stage; A is the leftmost digit, D the rightmost.
REQ-006 blank  input  4  per-digit blank request, active-high; bit3=A, bit2=B, bit1=C, bit0=D.
REQ-007 dp_en  input  4  per-digit decimal point, active-high; same bit mapping as blank.
REQ-008 an  output  4  anode selects, active-low; an[3]=A, an[2]=B, an[1]=C, an[0]=D.
REQ-009 seg  output  7  cathodes, active-low, seg[6:0]=g,f,e,d,c,b,a.
REQ-010 dp  output  1  decimal-point cathode, active-low.
REQ-011 frame_done  output  1  one-cycle pulse at the end of each full four-digit scan.

Function
REQ-012 The slot counter cnt SHALL count 0..CLK_DIV-1 and wrap to 0; width SHALL be $clog2(CLK_DIV).
REQ-013 The digit index idx SHALL advance on the cnt wrap edge in the order 0(A),1(B),2(C),3(D), then wrap from 3 to 0.
REQ-014 A, B, C, D, blank and dp_en SHALL be captured into frame registers only on the edge where cnt=CLK_DIV-1 and idx=3; mid-frame input changes SHALL NOT affect the current frame.
REQ-015 Outputs SHALL be registered and SHALL be updated on the same edge as cnt/idx. In the cycle holding state (cnt=k, idx=i), outputs SHALL reflect that (k, i).
REQ-016 Dead phase, cnt<DEAD_CYCLES: an=1111, seg=1111111, dp=1.
REQ-017 Active phase: an SHALL be low only on the bit for idx. seg SHALL carry the hex decode of the captured digit. dp SHALL be 0 if the captured dp_en bit is set, otherwise 1.
REQ-018 If the captured blank bit for idx is set, an SHALL stay 1111 for the whole slot, seg SHALL be 1111111 and dp SHALL be 1.
REQ-019 Hex decode SHALL cover all codes 0-F with the standard glyphs, including: 0=1000000, 1=1111001, 2=0100100, 4=0011001, 8=0000000, F=0001110.
REQ-020 frame_done SHALL be high exactly in the cycle after the capture edge (cnt=0, idx=0). The period SHALL be 4*CLK_DIV cycles.
REQ-021 Elaboration SHALL fail unless CLK_DIV >= DEAD_CYCLES+2 and DEAD_CYCLES >= 0.
REQ-022 At most one anode SHALL ever be low in any cycle.

Reset
REQ-023 While reset is high at a clock edge, the following SHALL load: cnt=0, idx=0, an=1111, seg=1111111, dp=1, frame_done=0, captured digits=0, captured blank=1111, captured dp_en=0000.
REQ-024 The display SHALL stay dark after reset until the first capture edge, i.e. for 4*CLK_DIV cycles.
REQ-025 Reset asserted mid-slot or mid-frame SHALL take priority over the capture edge and the frame_done pulse in the same cycle.

Structure
REQ-026 A shared package SHALL hold the 16-entry segment glyph constants, SEG_BLANK=1111111, AN_OFF=1111, and the digit-index type (2 bits).
REQ-027 Hex decode SHALL be implemented in one combinational sub-module, hex_to_seg (4-bit in, 7-bit active-low out). It SHALL be reusable by other display stages.

Verification (CLK_DIV=8, DEAD_CYCLES=2)
REQ-028 Reset, then hold A=1, B=2, C=3, D=4, blank=0, dp_en=0.
  - Cycles 0-31: an=1111.
  - A slot of the second frame: an=1111 at cnt 0-1, then an=0111 with seg=1111001 at cnt 2-7.
  - Then B slot shows an=1011, seg=0100100.
REQ-029 Change A from 1 to 8 at idx=1, cnt=3 -> the remainder of the frame is unchanged; the next A slot shows seg=0000000.
REQ-030 blank=0100 -> the B slot has an=1111 for all 8 cycles; the A, C and D slots are unaffected.
REQ-031 dp_en=0001 -> dp=0 only at D slot cnt 2-7; dp=1 everywhere else.
REQ-032 Assert reset at idx=2, cnt=5 for one cycle -> next cycle has cnt=0, idx=0, an=1111; no frame_done pulse; the display is dark for 32 cycles.
REQ-033 Free run for 10 frames -> frame_done pulses every 32 cycles exactly; a checker confirms REQ-022 on every cycle.
